// File: rtl/dec_alu_gen.sv
// Registered WIDTH-bit ALU with a sequential double-dabble converter driving a
// scanned, active-low seven-segment display (decimal or raw hex).
//   state | meaning
//   IDLE  | snapshot R into the shifter, clear BCD
//   SHIFT | 2*WIDTH add-3/shift iterations
//   DONE  | copy BCD into the display latch
module dec_alu_gen #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [3:0]        OpCode,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              DispCont,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        seg,
  output logic              c_out
);
  localparam int RW    = 2 * WIDTH;
  localparam int PW    = 4 * DIGITS;
  localparam int HEXD  = (RW + 3) / 4;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NSLOT = 1 << IW;
  localparam int CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW    = $clog2(RW);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  logic [RW-1:0]    alu_res, r_q, s_q;
  logic             alu_c;
  logic [WIDTH:0]   sum_ab, diff_ab, inc_a, dec_a;
  logic [WIDTH-1:0] low;

  always_comb begin
    sum_ab  = {1'b0, A} + {1'b0, B};
    diff_ab = {1'b0, A} - {1'b0, B};
    inc_a   = {1'b0, A} + (WIDTH+1)'(1);
    dec_a   = {1'b0, A} - (WIDTH+1)'(1);
    low     = '0;
    alu_c   = 1'b0;
    case (OpCode)
      4'd0:  begin low = sum_ab[WIDTH-1:0];  alu_c = sum_ab[WIDTH];  end
      4'd1:  begin low = diff_ab[WIDTH-1:0]; alu_c = diff_ab[WIDTH]; end
      4'd2:  low = A & B;
      4'd3:  low = A | B;
      4'd4:  low = A ^ B;
      4'd5:  low = ~(A | B);
      4'd6:  low = ~A;
      4'd7:  begin low = {A[WIDTH-2:0], 1'b0}; alu_c = A[WIDTH-1]; end
      4'd8:  begin low = {1'b0, A[WIDTH-1:1]}; alu_c = A[0];       end
      4'd9:  low = {A[WIDTH-2:0], A[WIDTH-1]};
      4'd10: low = {A[0], A[WIDTH-1:1]};
      4'd11: begin low = inc_a[WIDTH-1:0]; alu_c = inc_a[WIDTH]; end
      4'd12: begin low = dec_a[WIDTH-1:0]; alu_c = dec_a[WIDTH]; end
      4'd13: low = '0;
      4'd14: begin low = WIDTH'(A == B); alu_c = (A == B); end
      default: begin low = WIDTH'(A < B); alu_c = (A < B); end
    endcase
    alu_res = (OpCode == 4'd13) ? RW'(A) * RW'(B) : RW'(low);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_q   <= '0;
      c_out <= 1'b0;
    end else begin
      r_q   <= alu_res;
      c_out <= alu_c;
    end
  end

  state_t        state_q;
  logic [PW-1:0] bcd_q, bcd_adj, latch_q, latch_nxt;
  logic [SW-1:0] bit_cnt;

  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      s_q     <= '0;
      bcd_q   <= '0;
      bit_cnt <= '0;
      latch_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          s_q     <= r_q;
          bcd_q   <= '0;
          bit_cnt <= SW'(RW - 1);
          state_q <= SHIFT;
        end
        SHIFT: begin
          bcd_q   <= {bcd_adj[PW-2:0], s_q[RW-1]};
          s_q     <= {s_q[RW-2:0], 1'b0};
          bit_cnt <= bit_cnt - SW'(1);
          if (bit_cnt == '0) state_q <= DONE;
        end
        DONE: begin
          latch_q <= bcd_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Display path looks at next-cycle index and latch so a DONE coinciding with
  // a digit advance shows the fresh value straight away.
  assign latch_nxt = (state_q == DONE) ? bcd_q : latch_q;

  logic [CW-1:0]     ref_cnt;
  logic [IW-1:0]     idx_q, idx_nxt;
  logic              tc;
  logic [PW-1:0]     r_pad;
  logic [3:0]        nib [NSLOT];
  logic [NSLOT-1:0]  blank;
  logic              seen;
  logic [DIGITS-1:0] an_nxt;
  logic [6:0]        seg_nxt;

  always_comb begin
    tc      = (ref_cnt == CW'(REFRESH_DIV - 1));
    idx_nxt = idx_q;
    if (tc) idx_nxt = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    r_pad          = '0;
    r_pad[RW-1:0]  = r_q;
    seen  = 1'b0;
    blank = '1;
    for (int i = 0; i < NSLOT; i++) nib[i] = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (latch_nxt[4*i +: 4] != 4'd0);
      if (DispCont) begin
        nib[i]   = r_pad[4*i +: 4];
        blank[i] = (i >= HEXD);
      end else begin
        nib[i]   = latch_nxt[4*i +: 4];
        blank[i] = !seen && (i != 0);
      end
    end
    for (int i = 0; i < DIGITS; i++) an_nxt[i] = (idx_nxt != IW'(i));
    seg_nxt = blank[idx_nxt] ? 7'h7F : glyph(nib[idx_nxt]);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      ref_cnt <= '0;
      idx_q   <= '0;
      AN      <= ~DIGITS'(1);
      seg     <= 7'b1000000;
    end else begin
      ref_cnt <= tc ? '0 : ref_cnt + CW'(1);
      idx_q   <= idx_nxt;
      AN      <= an_nxt;
      seg     <= seg_nxt;
    end
  end
endmodule
